voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Upstream stage of the polyphonic engine: turns a serial stream of note-on/note-off events into 16 per-voice note numbers.
- Its output drives the 16 note inputs of the frequency-lookup stage, replacing the fixed chord sequencer.
- Handles free-voice search, retrigger of held notes, oldest-voice stealing, and a panic clear.

Parameters:
- VOICES, 16, number of voice slots; fixed at 16 for this design.
- NOTE_W, 7, note number width; 0 means silent.
- AGE_W, 4, per-voice age counter width; saturating.

Ports:
- clock48kHz  input  1  system sample clock.
- reset  input  1  asynchronous, active-high.
- ev_valid  input  1  event present.
- ev_ready  output  1  allocator can accept an event.
- ev_on  input  1  1 = note-on, 0 = note-off.
- ev_note  input  NOTE_W  note number of the event.
- all_off  input  1  panic: silence all voices.
- notes  output  VOICES*NOTE_W  voice i note at bits [i*7+6 : i*7]; 0 = silent.
- voice_active  output  VOICES  bit i = (note of voice i != 0).
- busy  output  1  = ~ev_ready.

Behaviour:
- Reset is asynchronous and active-high on clock48kHz. While reset is asserted:
  - FSM goes to IDLE.
  - All notes, ages and voice_active go to 0.
  - ev_ready = 1, busy = 0.
- FSM states: IDLE, SCAN, APPLY.
- Handshake: an event is accepted at a rising edge where ev_valid & ev_ready. ev_ready is high only in IDLE.
- On acceptance (edge E0): latch ev_on and ev_note; scan index = 0; go to SCAN.
- SCAN (edges E1..E16) examines voice idx = 0..15, one voice per cycle, and records:
  - match_idx: first voice whose note == latched note.
  - free_idx: first voice whose note == 0.
  - oldest_idx: voice with maximum age; ties resolve to the lowest index.
  - After idx = 15, go to APPLY.
- APPLY (edge E17) updates the registers, then returns to IDLE. New notes are visible and ev_ready = 1 after E17. Throughput is one event per 18 cycles.
- Note-on, ev_note != 0, resolved in this order:
  - match found: retrigger; target = match_idx, note unchanged.
  - else free found: target = free_idx; write note.
  - else: steal; target = oldest_idx; overwrite note.
  - In all three cases: age[target] = 0, and every other active voice's age increments, saturating at 2^AGE_W - 1.
- Note-off: if a match is found, note[match_idx] = 0 and age[match_idx] = 0. Otherwise nothing changes. Ages of other voices are untouched.
- ev_note == 0: accepted and runs the full latency, but APPLY changes nothing.
- A note is never held in two voices at once, which the retrigger rule guarantees.
- all_off, sampled on each rising edge, has the highest priority:
  - Clears all notes and ages.
  - Aborts any SCAN/APPLY in flight, dropping that event, and returns to IDLE.
  - If ev_valid is high in the same cycle, the event is not accepted: ev_ready is forced to 0 while all_off = 1.
- voice_active and notes are registered and change only at APPLY, all_off or reset.
- Reset asserted mid-SCAN: the event is lost and the block returns to the reset state.

Decomposition:
- Shared package synth_pkg holds:
  - VOICES = 16, NOTE_W = 7, NOTE_SILENT = 0.
  - The alloc_state enum {IDLE, SCAN, APPLY}.
  - A function packing 16 notes into the flat bus.
- One sub-module, voice_slot, instantiated VOICES times. It holds the note register and the saturating age counter, with inputs:
  - write_note, clear, age_reset, age_inc.
- The FSM and scan comparators live in voice_allocator.

Test Plan:
- Reset, then note-on 60: ev_ready drops for 17 cycles. Voice 0 = 60, voice_active = 0x0001, others 0. ev_ready = 1 on cycle 18.
- Note-on 60, 64, 67, then note-off 64: voices 0/1/2 = 60/64/67, then voice 1 = 0 and voice_active = 0x0005. A following note-on 72 lands in voice 1.
- Note-on 60 twice: only voice 0 holds 60, voice_active = 0x0001, age[0] = 0.
- Note-on 40..55 (16 notes), then note-on 70: voice 0 (the oldest, age 15) is replaced by 70; voices 1..15 keep 41..55.
- Note-on 60, then assert all_off during the SCAN of a second event (note-on 62): all notes = 0, voice_active = 0, ev_ready = 1 on the next cycle, and 62 never appears.
- Note-off 50 with no voice holding 50, and note-on 0: the notes bus is unchanged and each event takes 17 busy cycles.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the polyphonic engine: voice count, note widths,
// allocator state encoding and the helper that flattens per-voice notes.
package synth_pkg;

  localparam int VOICES = 16;
  localparam int NOTE_W = 7;
  localparam int AGE_W  = 4;
  localparam int IDX_W  = $clog2(VOICES);

  localparam logic [NOTE_W-1:0] NOTE_SILENT = '0;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    APPLY
  } alloc_state;

  // Voice i lands at bits [i*NOTE_W +: NOTE_W] of the flat bus.
  function automatic logic [VOICES*NOTE_W-1:0] pack_notes(input logic [NOTE_W-1:0] n [VOICES]);
    logic [VOICES*NOTE_W-1:0] flat;
    flat = '0;
    for (int i = 0; i < VOICES; i++) begin
      flat[i*NOTE_W +: NOTE_W] = n[i];
    end
    return flat;
  endfunction

endpackage

// File: rtl/voice_allocator_slot.sv
// One voice: its note register and a saturating age counter.
// Panic clear outranks any write; an age reset outranks an increment.
module voice_slot
  import synth_pkg::*;
(
  input  logic              clock48kHz,
  input  logic              reset,
  input  logic              clear,
  input  logic              write_note,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              age_reset,
  input  logic              age_inc,
  output logic [NOTE_W-1:0] note,
  output logic [AGE_W-1:0]  age
);

  always_ff @(posedge clock48kHz or posedge reset) begin
    if (reset) begin
      note <= NOTE_SILENT;
      age  <= '0;
    end else if (clear) begin
      note <= NOTE_SILENT;
      age  <= '0;
    end else begin
      if (write_note) begin
        note <= note_in;
      end
      if (age_reset) begin
        age <= '0;
      end else if (age_inc && (age != '1)) begin
        age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Serial note-on/off events to 16 voice note numbers: a 16-cycle scan finds
// match, free and oldest voices, then one APPLY cycle retriggers/allocates/steals.
module voice_allocator
  import synth_pkg::*;
(
  input  logic                     clock48kHz,
  input  logic                     reset,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic                     ev_on,
  input  logic [NOTE_W-1:0]        ev_note,
  input  logic                     all_off,
  output logic [VOICES*NOTE_W-1:0] notes,
  output logic [VOICES-1:0]        voice_active,
  output logic                     busy
);

  alloc_state state, state_next;

  logic              lat_on;
  logic [NOTE_W-1:0] lat_note;
  logic [IDX_W-1:0]  scan_idx;
  logic              match_found, free_found;
  logic [IDX_W-1:0]  match_idx, free_idx, oldest_idx;
  logic [AGE_W-1:0]  oldest_age;
  logic              accept;

  logic [NOTE_W-1:0] note_q [VOICES];
  logic [AGE_W-1:0]  age_q  [VOICES];
  logic [VOICES-1:0] write_en, age_rst, age_up;
  logic [NOTE_W-1:0] write_val;
  logic [IDX_W-1:0]  target;

  // Panic forces ready low so a same-cycle event cannot slip in.
  assign ev_ready = (state == IDLE) && !all_off;
  assign busy     = ~ev_ready;
  assign accept   = ev_valid && ev_ready;

  always_ff @(posedge clock48kHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (scan_idx == IDX_W'(VOICES - 1)) state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (all_off) state_next = IDLE;
  end

  // Oldest uses strict '>' so age ties stay on the lowest index.
  always_ff @(posedge clock48kHz or posedge reset) begin
    if (reset) begin
      lat_on      <= 1'b0;
      lat_note    <= NOTE_SILENT;
      scan_idx    <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      oldest_idx  <= '0;
      oldest_age  <= '0;
    end else if (accept) begin
      lat_on      <= ev_on;
      lat_note    <= ev_note;
      scan_idx    <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      oldest_idx  <= '0;
      oldest_age  <= '0;
    end else if (state == SCAN && !all_off) begin
      if (!match_found && note_q[scan_idx] == lat_note) begin
        match_found <= 1'b1;
        match_idx   <= scan_idx;
      end
      if (!free_found && note_q[scan_idx] == NOTE_SILENT) begin
        free_found <= 1'b1;
        free_idx   <= scan_idx;
      end
      if (age_q[scan_idx] > oldest_age) begin
        oldest_age <= age_q[scan_idx];
        oldest_idx <= scan_idx;
      end
      scan_idx <= scan_idx + 1'b1;
    end
  end

  always_comb begin
    write_en  = '0;
    age_rst   = '0;
    age_up    = '0;
    write_val = lat_on ? lat_note : NOTE_SILENT;
    target    = match_found ? match_idx : (free_found ? free_idx : oldest_idx);
    if (state == APPLY && lat_note != NOTE_SILENT) begin
      if (lat_on) begin
        for (int i = 0; i < VOICES; i++) begin
          if (IDX_W'(i) == target) begin
            write_en[i] = 1'b1;
            age_rst[i]  = 1'b1;
          end else begin
            age_up[i] = (note_q[i] != NOTE_SILENT);
          end
        end
      end else if (match_found) begin
        write_en[match_idx] = 1'b1;
        age_rst[match_idx]  = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_slot
    voice_slot u_slot (
      .clock48kHz (clock48kHz),
      .reset      (reset),
      .clear      (all_off),
      .write_note (write_en[g]),
      .note_in    (write_val),
      .age_reset  (age_rst[g]),
      .age_inc    (age_up[g]),
      .note       (note_q[g]),
      .age        (age_q[g])
    );
    assign voice_active[g] = (note_q[g] != NOTE_SILENT);
  end

  assign notes = pack_notes(note_q);

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random
// events compared against an array-based model of the allocation rules.
module tb_voice_allocator;
  import synth_pkg::*;

  logic                     clock48kHz = 1'b0;
  logic                     reset;
  logic                     ev_valid;
  logic                     ev_ready;
  logic                     ev_on;
  logic [NOTE_W-1:0]        ev_note;
  logic                     all_off;
  logic [VOICES*NOTE_W-1:0] notes;
  logic [VOICES-1:0]        voice_active;
  logic                     busy;

  int vectors = 0;
  int miscompares = 0;
  int m_note [VOICES];
  int m_age  [VOICES];

  always #5 clock48kHz = ~clock48kHz;

  voice_allocator dut (
    .clock48kHz   (clock48kHz),
    .reset        (reset),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .all_off      (all_off),
    .notes        (notes),
    .voice_active (voice_active),
    .busy         (busy)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < VOICES; i++) begin
      m_note[i] = 0;
      m_age[i]  = 0;
    end
  endfunction

  // Voice selection straight from the rules: retrigger, else first free, else oldest.
  function automatic void model_event(input bit on, input int note);
    int match, free, oldest, tgt;
    if (note == 0) return;
    match = -1; free = -1; oldest = 0;
    for (int i = 0; i < VOICES; i++) begin
      if (match < 0 && m_note[i] == note) match = i;
      if (free < 0 && m_note[i] == 0) free = i;
      if (m_age[i] > m_age[oldest]) oldest = i;
    end
    if (on) begin
      tgt = (match >= 0) ? match : ((free >= 0) ? free : oldest);
      for (int i = 0; i < VOICES; i++) begin
        if (i != tgt && m_note[i] != 0) m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
      end
      m_note[tgt] = note;
      m_age[tgt]  = 0;
    end else if (match >= 0) begin
      m_note[match] = 0;
      m_age[match]  = 0;
    end
  endfunction

  function automatic logic [VOICES*NOTE_W-1:0] model_bus();
    logic [VOICES*NOTE_W-1:0] b;
    b = '0;
    for (int i = 0; i < VOICES; i++) b[i*NOTE_W +: NOTE_W] = NOTE_W'(m_note[i]);
    return b;
  endfunction

  function automatic logic [VOICES-1:0] model_active();
    logic [VOICES-1:0] a;
    for (int i = 0; i < VOICES; i++) a[i] = (m_note[i] != 0);
    return a;
  endfunction

  task automatic check_model(input string tag);
    checkOutput({tag, ".notes"}, notes, model_bus());
    checkOutput({tag, ".active"}, voice_active, model_active());
  endtask

  // Issue one event from a negedge, count busy cycles, then compare with the model.
  task automatic applyStimulus(input bit on, input int note);
    int waited, busy_cycles;
    waited = 0;
    while (!ev_ready && waited < 40) begin
      @(negedge clock48kHz);
      waited++;
    end
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = NOTE_W'(note);
    @(posedge clock48kHz);
    #1;
    ev_valid = 1'b0;
    @(negedge clock48kHz);
    checkOutput($sformatf("hold_%0d_%0d", on, note), notes, model_bus());
    busy_cycles = 0;
    while (!ev_ready && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clock48kHz);
    end
    checkOutput($sformatf("latency_%0d_%0d", on, note), busy_cycles, 17);
    checkOutput("busy_idle", busy, 1'b0);
    model_event(on, note);
    check_model($sformatf("ev_%0d_%0d", on, note));
  endtask

  task automatic do_reset();
    @(negedge clock48kHz);
    reset = 1'b1;
    #2;
    checkOutput("rst.ready", ev_ready, 1'b1);
    checkOutput("rst.notes", notes, '0);
    @(negedge clock48kHz);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic start_only(input int note);
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_note  = NOTE_W'(note);
    @(posedge clock48kHz);
    #1;
    ev_valid = 1'b0;
  endtask

  initial begin
    int r, note;
    bit on;
    reset = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; all_off = 1'b0;
    model_clear();
    #1;
    checkOutput("reset.ready", ev_ready, 1'b1);
    checkOutput("reset.busy", busy, 1'b0);
    checkOutput("reset.notes", notes, '0);
    checkOutput("reset.active", voice_active, '0);
    @(negedge clock48kHz);
    @(negedge clock48kHz);
    reset = 1'b0;

    applyStimulus(1'b1, 60);
    checkOutput("first.v0", notes[6:0], 7'd60);
    checkOutput("first.active", voice_active, 16'h0001);

    applyStimulus(1'b1, 64);
    applyStimulus(1'b1, 67);
    applyStimulus(1'b0, 64);
    checkOutput("off64.active", voice_active, 16'h0005);
    applyStimulus(1'b1, 72);
    checkOutput("refill.v1", notes[13:7], 7'd72);

    do_reset();
    applyStimulus(1'b1, 60);
    applyStimulus(1'b1, 60);
    checkOutput("retrig.active", voice_active, 16'h0001);
    checkOutput("retrig.v0", notes[6:0], 7'd60);

    do_reset();
    for (int n = 40; n <= 55; n++) applyStimulus(1'b1, n);
    applyStimulus(1'b1, 70);
    checkOutput("steal.v0", notes[6:0], 7'd70);
    checkOutput("steal.v1", notes[13:7], 7'd41);
    checkOutput("steal.v15", notes[111:105], 7'd55);

    do_reset();
    applyStimulus(1'b1, 60);
    start_only(62);
    repeat (5) @(negedge clock48kHz);
    all_off = 1'b1;
    #1;
    checkOutput("panic.ready_low", ev_ready, 1'b0);
    checkOutput("panic.busy", busy, 1'b1);
    @(posedge clock48kHz);
    #1;
    checkOutput("panic.notes", notes, '0);
    checkOutput("panic.active", voice_active, '0);
    @(negedge clock48kHz);
    all_off = 1'b0;
    #1;
    checkOutput("panic.ready", ev_ready, 1'b1);
    model_clear();
    repeat (20) @(negedge clock48kHz);
    check_model("panic.no62");

    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd33; all_off = 1'b1;
    @(posedge clock48kHz);
    #1;
    ev_valid = 1'b0; all_off = 1'b0;
    @(negedge clock48kHz);
    checkOutput("panic_ev.ready", ev_ready, 1'b1);
    repeat (20) @(negedge clock48kHz);
    check_model("panic_ev.dropped");

    applyStimulus(1'b1, 60);
    applyStimulus(1'b0, 50);
    applyStimulus(1'b1, 0);
    checkOutput("noop.v0", notes[6:0], 7'd60);

    start_only(61);
    repeat (4) @(negedge clock48kHz);
    reset = 1'b1;
    #1;
    checkOutput("midrst.ready", ev_ready, 1'b1);
    checkOutput("midrst.notes", notes, '0);
    @(negedge clock48kHz);
    reset = 1'b0;
    model_clear();
    repeat (20) @(negedge clock48kHz);
    check_model("midrst.lost");

    for (int k = 0; k < 250; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        all_off = 1'b1;
        @(negedge clock48kHz);
        all_off = 1'b0;
        model_clear();
        check_model("rnd.panic");
      end else begin
        on   = (r < 70);
        note = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
        applyStimulus(on, note);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
